mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter nbits, default 32, SHALL set the address width.
REQ-003 Parameter LAT, default 2, SHALL set the memory access length in cycles; legal range 1..16.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0  input  1  instruction-fetch requester; held high until done0.
REQ-007 req1  input  1  data load/store requester; held high until done1.
REQ-008 addr0  input  nbits  fetch address; stable while gnt0=1.
REQ-009 addr1  input  nbits  data address; stable while gnt1=1.
REQ-010 gnt0, gnt1  output  1 each  registered grant; at most one high.
REQ-011 done0, done1  output  1 each  one-cycle pulse on the last cycle of an access.
REQ-012 sel  output  1  shared-port mux select; 0 = requester 0, 1 = requester 1.
REQ-013 mem_en  output  1  memory enable; high in every granted cycle.
REQ-014 mem_addr  output  nbits  combinational: addr1 when sel=1, else addr0.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT0, GRANT1.
REQ-016 In IDLE with any req high, the block SHALL enter GRANTx on the next edge; grant latency is one cycle from req.
REQ-017 When both reqs are high, the block SHALL grant the requester not served most recently (round-robin on last_served).
REQ-018 On entry to GRANTx: gntx=1, sel=x, mem_en=1; a cycle counter SHALL load LAT-1.
REQ-019 The counter SHALL decrement once per GRANT cycle; in the cycle it reads 0, donex SHALL pulse high and last_served SHALL update to x.
REQ-020 Each access SHALL hold the port exactly LAT cycles; LAT=1 SHALL give donex in the first granted cycle.
REQ-021 In a done cycle, req lines SHALL be re-arbitrated by REQ-017 with last_served already updated; the next grant SHALL start on the following edge with no idle bubble. With no req high, the FSM SHALL return to IDLE.
REQ-022 A requester holding req high through its done cycle while the other is idle SHALL be granted again back-to-back.
REQ-023 Deassertion of the granted req before donex SHALL be ignored; the access SHALL complete and donex SHALL still pulse.
REQ-024 A req arriving for the non-granted requester mid-access SHALL wait; no pre-emption.
REQ-025 sel SHALL hold its last value in IDLE; gnt0, gnt1, mem_en, done0 and done1 SHALL be 0 in IDLE.
REQ-026 The counter width SHALL be 4 bits; counter wrap SHALL NOT occur in any state.

Reset
REQ-027 While rst=1: state=IDLE; gnt0=gnt1=done0=done1=mem_en=sel=0; counter=0; last_served=1, so requester 0 wins the first tie.
REQ-028 rst asserted mid-access SHALL abort the access with no done pulse; arbitration SHALL resume on the first edge after rst falls.

Structure
REQ-029 State encodings (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10) SHALL be constants in the shared mips_pkg package.
REQ-030 mem_addr SHALL come from one instance of the existing MUX sub-module (nbits wide, sel-driven); the FSM and counter SHALL stay in this module.

Verification (LAT=2 unless stated)
REQ-031 Reset, then req0=1 at cycle 0, addr0=0x0040 -> gnt0=1 in cycles 1-2, mem_addr=0x0040, done0 in cycle 2, IDLE in cycle 3 after req0 drops.
REQ-032 req0=req1=1 held continuously -> grants alternate 0,1,0,1 every 2 cycles with no idle cycle; sel toggles every 2 cycles.
REQ-033 req1 rises in cycle 1 of a GRANT0 access -> GRANT0 completes (done0 in cycle 2), gnt1 rises in cycle 3.
REQ-034 req0 drops in cycle 1 of its grant -> done0 still pulses in cycle 2; no regrant.
REQ-035 rst pulsed in cycle 1 of GRANT1 -> no done1; all outputs 0 next cycle; simultaneous req0=req1 afterwards -> requester 0 granted first.
REQ-036 LAT=1, req1 held high alone -> gnt1 and done1 high every cycle from cycle 1 on.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the memory port arbiter
package mips_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

endpackage

// File: rtl/mux.sv
// rtl/mux.sv - two-input nbits-wide select mux for the shared memory port
module mux #(
  parameter int nbits = 32
) (
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  input  logic             sel,
  output logic [nbits-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int nbits = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [nbits-1:0] addr0,
  input  logic [nbits-1:0] addr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             sel,
  output logic             mem_en,
  output logic [nbits-1:0] mem_addr
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_served, last_nxt;
  logic             sel_q, sel_nxt;
  logic             finishing;
  logic             arb_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      sel_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_served <= last_nxt;
      sel_q       <= sel_nxt;
    end
  end

  // In a done cycle arbitration already sees the updated last_served,
  // so a waiting requester is granted on the next edge with no bubble.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_served;
    sel_nxt   = sel_q;
    finishing = 1'b0;
    arb_last  = last_served;
    case (state)
      GRANT0: if (cnt == '0) begin
        finishing = 1'b1;
        arb_last  = 1'b0;
      end
      GRANT1: if (cnt == '0) begin
        finishing = 1'b1;
        arb_last  = 1'b1;
      end
      default: ;
    endcase
    if (state == IDLE || finishing) begin
      last_nxt = arb_last;
      if (req0 && (!req1 || arb_last)) begin
        state_nxt = GRANT0;
        cnt_nxt   = LOAD;
        sel_nxt   = 1'b0;
      end else if (req1) begin
        state_nxt = GRANT1;
        cnt_nxt   = LOAD;
        sel_nxt   = 1'b1;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_comb begin
    gnt0   = (state == GRANT0);
    gnt1   = (state == GRANT1);
    done0  = gnt0 && (cnt == '0);
    done1  = gnt1 && (cnt == '0);
    mem_en = gnt0 || gnt1;
    sel    = sel_q;
  end

  mux #(
    .nbits(nbits)
  ) u_addr_mux (
    .in0(addr0),
    .in1(addr1),
    .sel(sel_q),
    .y  (mem_addr)
  );

endmodule
